// File: rtl/tree_walker.sv
// tree_walker: table-driven decision-tree classifier, one node per clock.
// Ports: in_* feature handshake, out_* result handshake, cfg_* node table
// write port, busy. Optional macro TREE_WALKER_STEP_LIMIT_EN adds a walk
// step limit (MAX_STEPS) that flags cyclic tables through out_err.
module tree_walker #(
  parameter int N_FEAT    = 51,
  parameter int N_NODES   = 64,
  parameter int CLASS_W   = 2,
  parameter int MAX_STEPS = 32,
  localparam int FW     = $clog2(N_FEAT),
  localparam int AW     = $clog2(N_NODES),
  localparam int NODE_W = 1 + FW + 2 * AW,
  localparam int SW     = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FEAT-1:0] in_feat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic              out_err,
  output logic [SW-1:0]     out_steps,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [NODE_W-1:0] cfg_wdata,
  output logic              cfg_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_t;

  localparam logic [NODE_W-1:0] LEAF0 =
    {1'b1, {(NODE_W-1){1'b0}}};

  state_t state_q, state_d;

  logic [NODE_W-1:0]  node_tbl [N_NODES];
  logic [N_FEAT-1:0]  feat_q;
  logic [AW-1:0]      ptr_q;
  logic [SW-1:0]      steps_q;
  logic [CLASS_W-1:0] cls_q;

  logic [NODE_W-1:0]  node;
  logic               is_leaf;
  logic [FW-1:0]      sel;
  logic [AW-1:0]      child_hi;
  logic [AW-1:0]      child_lo;
  logic [2**FW-1:0]   feat_pad;
  logic               fbit;
  logic [AW-1:0]      next_ptr;
  logic               limit_hit;

  assign node     = node_tbl[ptr_q];
  assign is_leaf  = node[NODE_W-1];
  assign sel      = node[NODE_W-2 -: FW];
  assign child_hi = node[2*AW-1 -: AW];
  assign child_lo = node[AW-1:0];

  // Selects past the top feature read as zero via the padding.
  always_comb begin
    feat_pad = '0;
    feat_pad[N_FEAT-1:0] = feat_q;
  end

  assign fbit     = feat_pad[sel];
  assign next_ptr = fbit ? child_hi : child_lo;

`ifdef TREE_WALKER_STEP_LIMIT_EN
  logic err_q;
  assign limit_hit = (steps_q == SW'(MAX_STEPS));
  assign out_err   = err_q;
`else
  assign limit_hit = 1'b0;
  assign out_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
        if (in_valid) state_d = WALK;
      end
      WALK: begin
        if (is_leaf || limit_hit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign out_class = cls_q;
  assign out_steps = steps_q;

  // Writes only land in IDLE, so a walk always sees a stable table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NODES; i++) node_tbl[i] <= LEAF0;
    end else if (cfg_we && state_q == IDLE) begin
      node_tbl[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q  <= '0;
      ptr_q   <= '0;
      steps_q <= '0;
      cls_q   <= '0;
`ifdef TREE_WALKER_STEP_LIMIT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            feat_q  <= in_feat;
            ptr_q   <= '0;
            steps_q <= '0;
            cls_q   <= '0;
`ifdef TREE_WALKER_STEP_LIMIT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        WALK: begin
          if (is_leaf) begin
            cls_q <= child_lo[CLASS_W-1:0];
          end else if (limit_hit) begin
            cls_q <= '0;
`ifdef TREE_WALKER_STEP_LIMIT_EN
            err_q <= 1'b1;
`endif
          end else begin
            ptr_q   <= next_ptr;
            steps_q <= steps_q + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tree_walker.sv
// tb_tree_walker: directed self-checking bench for tree_walker.
// Hand-computed vectors for reset, walks, backpressure, cfg and reset.
module tb_tree_walker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [50:0] in_feat;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_class;
  logic        out_err;
  logic [5:0]  out_steps;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [18:0] cfg_wdata;
  logic        cfg_ready;
  logic        busy;

  int checks = 0;
  int failures = 0;

  localparam logic [50:0] F24 = 51'd1 << 24;
  localparam logic [50:0] F37 = 51'd1 << 37;
  localparam logic [50:0] F50 = 51'd1 << 50;
  localparam logic [50:0] ONES = {51{1'b1}};

  tree_walker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .out_steps (out_steps),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] nd(input bit leaf, input int sel,
                                     input int hi, input int lo);
    return {leaf, 6'(sel), 6'(hi), 6'(lo)};
  endfunction

  task automatic cfg_write(input logic [5:0] a, input logic [18:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic walk(input logic [50:0] f, input bit do_cfg,
                      input logic [5:0] ca, input logic [18:0] cd,
                      output int lat, output logic [1:0] c,
                      output logic [5:0] s, output logic e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_feat = f;
    in_valid = 1'b1;
    if (do_cfg) begin
      cfg_we = 1'b1;
      cfg_addr = ca;
      cfg_wdata = cd;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    c = out_class;
    s = out_steps;
    e = out_err;
    if (out_valid) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    int lat;
    logic [1:0] c;
    logic [5:0] s;
    logic e;
    #1;
    checks++;
    if ({out_valid, busy, out_err, out_class, out_steps} !== '0) begin
      failures++;
      $display("FAIL reset_outs got v=%b b=%b e=%b c=%0d s=%0d exp all 0",
               out_valid, busy, out_err, out_class, out_steps);
    end
    checks++;
    if ({in_ready, cfg_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got %b%b exp 11", in_ready, cfg_ready);
    end
    walk('0, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (lat !== 1 || c !== 2'd0 || s !== 6'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL reset_walk got lat=%0d c=%0d s=%0d e=%b exp 1 0 0 0",
               lat, c, s, e);
    end
  endtask

  task automatic test_tree;
    int lat;
    logic [1:0] c;
    logic [5:0] s;
    logic e;
    cfg_write(6'd0, nd(0, 24, 1, 2));
    cfg_write(6'd1, nd(0, 37, 3, 4));
    cfg_write(6'd2, nd(1, 0, 0, 1));
    cfg_write(6'd3, nd(1, 0, 0, 2));
    cfg_write(6'd4, nd(1, 0, 0, 3));
    walk(F24 | F37, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (lat !== 3 || c !== 2'd2 || s !== 6'd2 || e !== 1'b0) begin
      failures++;
      $display("FAIL tree_hh got lat=%0d c=%0d s=%0d e=%b exp 3 2 2 0",
               lat, c, s, e);
    end
    walk(F37, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (lat !== 2 || c !== 2'd1 || s !== 6'd1) begin
      failures++;
      $display("FAIL tree_lo got lat=%0d c=%0d s=%0d exp 2 1 1",
               lat, c, s);
    end
    walk(F24, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (lat !== 3 || c !== 2'd3 || s !== 6'd2) begin
      failures++;
      $display("FAIL tree_hl got lat=%0d c=%0d s=%0d exp 3 3 2",
               lat, c, s);
    end
  endtask

  task automatic test_sel_bounds;
    int lat;
    logic [1:0] c;
    logic [5:0] s;
    logic e;
    cfg_write(6'd0, nd(0, 60, 1, 2));
    walk(ONES, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (c !== 2'd1 || s !== 6'd1) begin
      failures++;
      $display("FAIL sel_oob got c=%0d s=%0d exp 1 1", c, s);
    end
    cfg_write(6'd0, nd(0, 50, 1, 2));
    walk(F50, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (c !== 2'd3 || s !== 6'd2) begin
      failures++;
      $display("FAIL sel_top got c=%0d s=%0d exp 3 2", c, s);
    end
    cfg_write(6'd0, nd(0, 24, 1, 2));
  endtask

  task automatic test_backpressure;
    int n = 0;
    int bad = 0;
    out_ready = 1'b0;
    @(negedge clk);
    in_feat = F24 | F37;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL bp_latency got %0d exp 3", n);
    end
    in_feat = F37;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_class !== 2'd2 ||
          out_steps !== 6'd2 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold got %0d unstable cycles exp 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got v=%b r=%b exp 0 1",
               out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accept got busy=%b r=%b exp 1 0", busy, in_ready);
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b1 || out_class !== 2'd1 || out_steps !== 6'd1)
    begin
      failures++;
      $display("FAIL bp_next got v=%b c=%0d s=%0d exp 1 1 1",
               out_valid, out_class, out_steps);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cfg_during_walk;
    int lat;
    int n = 0;
    logic [1:0] c;
    logic [5:0] s;
    logic e;
    @(negedge clk);
    in_feat = F24 | F37;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL cfg_ready_walk got %b exp 0", cfg_ready);
    end
    cfg_we = 1'b1;
    cfg_addr = 6'd3;
    cfg_wdata = nd(1, 0, 0, 1);
    @(negedge clk);
    cfg_we = 1'b0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_class !== 2'd2) begin
      failures++;
      $display("FAIL cfg_walk_ignored got v=%b c=%0d exp 1 2",
               out_valid, out_class);
    end
    walk(F24 | F37, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (c !== 2'd2) begin
      failures++;
      $display("FAIL cfg_rerun got c=%0d exp 2", c);
    end
    walk(F24 | F37, 1'b1, 6'd3, nd(1, 0, 0, 1), lat, c, s, e);
    checks++;
    if (c !== 2'd1 || s !== 6'd2 || lat !== 3) begin
      failures++;
      $display("FAIL cfg_idle_same got c=%0d s=%0d lat=%0d exp 1 2 3",
               c, s, lat);
    end
  endtask

`ifdef TREE_WALKER_STEP_LIMIT_EN
  task automatic test_loop_guard;
    int lat;
    logic [1:0] c;
    logic [5:0] s;
    logic e;
    cfg_write(6'd0, nd(0, 0, 0, 0));
    walk(ONES, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (lat !== 33 || c !== 2'd0 || s !== 6'd32 || e !== 1'b1) begin
      failures++;
      $display("FAIL loop_guard got lat=%0d c=%0d s=%0d e=%b exp 33 0 32 1",
               lat, c, s, e);
    end
  endtask
`endif

  task automatic test_reset_mid_walk;
    int lat;
    int spur = 0;
    logic [1:0] c;
    logic [5:0] s;
    logic e;
    cfg_write(6'd0, nd(0, 0, 0, 0));
    @(negedge clk);
    in_feat = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_walk_busy got b=%b v=%b exp 1 0", busy, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        cfg_ready !== 1'b1 || out_steps !== 6'd0) begin
      failures++;
      $display("FAIL mid_reset got v=%b b=%b r=%b cr=%b s=%0d exp 0 0 1 1 0",
               out_valid, busy, in_ready, cfg_ready, out_steps);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (out_valid) spur++;
    end
    checks++;
    if (spur != 0) begin
      failures++;
      $display("FAIL mid_spurious got %0d exp 0", spur);
    end
    walk(ONES, 1'b0, '0, '0, lat, c, s, e);
    checks++;
    if (lat !== 1 || c !== 2'd0 || s !== 6'd0 || e !== 1'b0) begin
      failures++;
      $display("FAIL mid_table got lat=%0d c=%0d s=%0d e=%b exp 1 0 0 0",
               lat, c, s, e);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_feat = '0;
    out_ready = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_tree();
    test_sel_bounds();
    test_backpressure();
    test_cfg_during_walk();
`ifdef TREE_WALKER_STEP_LIMIT_EN
    test_loop_guard();
`endif
    test_reset_mid_walk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
